pov_digit_renderer: RTL

- Renders a row of glyphs onto a single vertical LED column for the persistence-of-vision clock.
- On each rotation trigger it snapshots NUM_DIGITS glyph codes, then emits a timed column sequence: front padding, glyph columns, inter-digit gaps.
- Sits between the timekeeping counters (which supply BCD digits and colon codes) and the LED driver pins.
- Parametrised successor to the fixed six-digit display: digit count, pixel period and spacing are generics; it adds frame status and a font ROM.

---
 rtl/pov_pkg.sv | 19 +
 rtl/pov_font_rom.sv | 36 +++
 rtl/pov_digit_renderer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pov_pkg.sv
// Shared definitions for the POV clock digit renderer.
// Glyph code constants, font geometry and the renderer FSM encoding.
package pov_pkg;

    localparam int FONT_COLS = 5;
    localparam int LED_ROWS  = 7;
    localparam int CODE_W    = 5;

    localparam logic [CODE_W-1:0] CODE_COLON = 5'd10;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd11;

    typedef enum logic [1:0] {
        IDLE,
        FRONT,
        GLYPH,
        GAP
    } pov_state_t;

endpackage

// File: rtl/pov_font_rom.sv
// 5x7 column font for numerals and colon; bit 0 is the top row.
// Codes above the colon, and columns past the glyph width, read as blank.
module pov_font_rom
    import pov_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    input  logic [2:0]          col,
    output logic [LED_ROWS-1:0] column
);

    logic [0:FONT_COLS-1][LED_ROWS-1:0] glyph;

    // Select the glyph by code, then pick one of its columns
    always_comb begin
        glyph = '0;
        case (code)
            5'd0:       glyph = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            5'd1:       glyph = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            5'd2:       glyph = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            5'd3:       glyph = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            5'd4:       glyph = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            5'd5:       glyph = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            5'd6:       glyph = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            5'd7:       glyph = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            5'd8:       glyph = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            5'd9:       glyph = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            CODE_COLON: glyph = {7'h00, 7'h36, 7'h36, 7'h00, 7'h00};
            default:    glyph = '0;
        endcase
        column = '0;
        if (col < 3'(FONT_COLS)) begin
            column = glyph[col];
        end
    end

endmodule

// File: rtl/pov_digit_renderer.sv
// Renders a snapshot of glyph codes as a timed LED column sequence.
// Optional POV_RETRIGGER_EN: trigger while busy restarts the frame.
module pov_digit_renderer
    import pov_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int CLKS_PER_PIXEL = 20000000,
    parameter int FRONT_PAD      = 10,
    parameter int DIGIT_PAD      = 2
) (
    input  logic                         board_clk,
    input  logic                         Reset,
    input  logic                         trigger,
    input  logic [NUM_DIGITS*CODE_W-1:0] digits,
    output logic [LED_ROWS-1:0]          leds,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int PIX_W   = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PAD_MAX = (FRONT_PAD > DIGIT_PAD) ? FRONT_PAD : DIGIT_PAD;
    localparam int PAD_W   = (PAD_MAX > 1) ? $clog2(PAD_MAX) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(CLKS_PER_PIXEL - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [PAD_W-1:0] FRONT_LAST = PAD_W'((FRONT_PAD > 0) ? FRONT_PAD - 1 : 0);
    localparam logic [PAD_W-1:0] GAP_LAST   = PAD_W'((DIGIT_PAD > 0) ? DIGIT_PAD - 1 : 0);
    localparam logic [2:0]       COL_LAST   = 3'(FONT_COLS - 1);

    pov_state_t                  state;
    logic [NUM_DIGITS*CODE_W-1:0] snap;
    logic [DIG_W-1:0]            digit_idx;
    logic [2:0]                  col_idx;
    logic [PIX_W-1:0]            pix_cnt;
    logic [PAD_W-1:0]            pad_cnt;
    logic                        pix_tick;
    logic                        accept;

    logic [NUM_DIGITS*CODE_W-1:0] rom_src;
    logic [DIG_W-1:0]            rom_dig;
    logic [2:0]                  rom_col;
    logic [CODE_W-1:0]           rom_code;
    logic [LED_ROWS-1:0]         rom_out;

    assign pix_tick = (pix_cnt == PIX_LAST);

`ifdef POV_RETRIGGER_EN
    assign accept = trigger;
`else
    assign accept = trigger && (state == IDLE);
`endif

    // Point the font lookup at the column that becomes visible next
    always_comb begin
        rom_src = snap;
        rom_dig = digit_idx;
        rom_col = col_idx + 3'd1;
        if (accept) begin
            rom_src = digits;
            rom_dig = '0;
            rom_col = '0;
        end else if (state != GLYPH || col_idx == COL_LAST) begin
            rom_col = '0;
            if (state != FRONT) begin
                rom_dig = digit_idx + 1'b1;
            end
        end
    end

    // Extract the selected slot's code; out-of-range slots read blank
    always_comb begin
        rom_code = CODE_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rom_dig == DIG_W'(i)) begin
                rom_code = rom_src[CODE_W*i +: CODE_W];
            end
        end
    end

    pov_font_rom u_font (
        .code   (rom_code),
        .col    (rom_col),
        .column (rom_out)
    );

    // Frame sequencer with registered column, busy and done outputs
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            snap       <= '0;
            digit_idx  <= '0;
            col_idx    <= '0;
            pix_cnt    <= '0;
            pad_cnt    <= '0;
            leds       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                snap      <= digits;
                digit_idx <= '0;
                col_idx   <= '0;
                pix_cnt   <= '0;
                pad_cnt   <= '0;
                busy      <= 1'b1;
                if (FRONT_PAD == 0) begin
                    state <= GLYPH;
                    leds  <= rom_out;
                end else begin
                    state <= FRONT;
                    leds  <= '0;
                end
            end else if (state == IDLE) begin
                leds <= '0;
                busy <= 1'b0;
            end else begin
                pix_cnt <= pix_tick ? '0 : pix_cnt + 1'b1;
                if (pix_tick) begin
                    case (state)
                        FRONT: begin
                            if (pad_cnt == FRONT_LAST) begin
                                pad_cnt <= '0;
                                state   <= GLYPH;
                                leds    <= rom_out;
                            end else begin
                                pad_cnt <= pad_cnt + 1'b1;
                            end
                        end
                        GLYPH: begin
                            if (col_idx == COL_LAST) begin
                                col_idx <= '0;
                                if (digit_idx == DIG_LAST) begin
                                    state      <= IDLE;
                                    busy       <= 1'b0;
                                    leds       <= '0;
                                    frame_done <= 1'b1;
                                end else if (DIGIT_PAD == 0) begin
                                    digit_idx <= digit_idx + 1'b1;
                                    leds      <= rom_out;
                                end else begin
                                    state <= GAP;
                                    leds  <= '0;
                                end
                            end else begin
                                col_idx <= col_idx + 3'd1;
                                leds    <= rom_out;
                            end
                        end
                        GAP: begin
                            if (pad_cnt == GAP_LAST) begin
                                pad_cnt   <= '0;
                                digit_idx <= digit_idx + 1'b1;
                                state     <= GLYPH;
                                leds      <= rom_out;
                            end else begin
                                pad_cnt <= pad_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            leds  <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
